// File: rtl/vram_pkg.sv
// vram_pkg: shared types and constants for the dual-port video memory.
package vram_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ADDR_W = 13;
    localparam int unsigned DEF_DEPTH  = 8192;

    // Words returned for out-of-range reads; truncated to DATA_W at the use site.
    localparam logic [63:0] HOST_OOR_WORD = '1;
    localparam logic [63:0] DISP_OOR_WORD = '0;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/vram_if.sv
// vram_if: host-side access bus of the video memory.
interface vram_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 13
);
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wr_data;
    logic              host_select;
    logic              host_rd;
    logic [DATA_W-1:0] host_rd_data;
    logic              host_rd_valid;
    logic              host_busy;

    modport master (
        output host_addr, host_wr_data, host_select, host_rd,
        input  host_rd_data, host_rd_valid, host_busy
    );

    modport slave (
        input  host_addr, host_wr_data, host_select, host_rd,
        output host_rd_data, host_rd_valid, host_busy
    );
endinterface

// File: rtl/vram_fill_ctrl.sv
// vram_fill_ctrl: fill engine that paints a wrapping address range with one word.
module vram_fill_ctrl
    import vram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W:0]   count_i,
    input  logic [DATA_W-1:0] value_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);
    localparam int unsigned       CNT_W     = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fill_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic              done_q, done_d;

    // Next-state: latch the job in idle, step address/count while filling.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        // Registered strobe: high in the cycle after the DONE state.
        done_d  = (state_q == FILL_DONE);
        case (state_q)
            FILL_IDLE: begin
                if (start_i) begin
                    addr_d  = ADDR_W'(32'(base_i) % DEPTH);
                    cnt_d   = count_i;
                    value_d = value_i;
                    state_d = (count_i == '0) ? FILL_DONE : FILL_RUN;
                end
            end
            FILL_RUN: begin
                addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FILL_DONE;
                end
            end
            FILL_DONE: state_d = FILL_IDLE;
            default:   state_d = FILL_IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            done_q  <= done_d;
        end
    end

    assign busy_o    = (state_q != FILL_IDLE);
    assign done_o    = done_q;
    // Reset aborts immediately, so no write lands on the reset edge.
    assign wr_en_o   = (state_q == FILL_RUN) && !rst;
    assign wr_addr_o = addr_q;
    assign wr_data_o = value_q;

endmodule

// File: rtl/vram_dp.sv
// vram_dp: dual-port video memory with host port, fill engine and display read port.
// Optional macro VRAM_DISPLAY_OUTREG_EN adds a second display output register stage.
module vram_dp
    import vram_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    vram_if.slave             host,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_count,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_done,
    input  logic [ADDR_W-1:0] display_addr,
    output logic [DATA_W-1:0] display_rd_data
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fill_busy, fill_we;
    logic [ADDR_W-1:0] fill_waddr;
    logic [DATA_W-1:0] fill_wdata;

    vram_fill_ctrl #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .start_i   (fill_start),
        .base_i    (fill_base),
        .count_i   (fill_count),
        .value_i   (fill_value),
        .busy_o    (fill_busy),
        .done_o    (fill_done),
        .wr_en_o   (fill_we),
        .wr_addr_o (fill_waddr),
        .wr_data_o (fill_wdata)
    );

    logic host_in_range, disp_in_range, host_rd_acc, host_wr_acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, disp_q, disp_d;
    logic              rd_valid_q, rd_valid_d;

    assign host_in_range = ({1'b0, host.host_addr} < DEPTH_W);
    assign disp_in_range = ({1'b0, display_addr} < DEPTH_W);
    // Host accesses during a fill are dropped, so the write port never contends.
    assign host_rd_acc   = host.host_select && !fill_busy && host.host_rd;
    assign host_wr_acc   = host.host_select && !fill_busy && !host.host_rd && host_in_range;

    // Write-port mux between the fill engine and the host.
    always_comb begin
        mem_we    = fill_we || host_wr_acc;
        mem_waddr = fill_we ? fill_waddr : host.host_addr;
        mem_wdata = fill_we ? fill_wdata : host.host_wr_data;
    end

    // Memory array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read-port next values; reads see the pre-write word (read-first).
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = host_rd_acc;
        if (host_rd_acc) begin
            rd_data_d = host_in_range ? mem[host.host_addr] : DATA_W'(HOST_OOR_WORD);
        end
        disp_d = disp_in_range ? mem[display_addr] : DATA_W'(DISP_OOR_WORD);
    end

    // Read-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            disp_q     <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            disp_q     <= disp_d;
        end
    end

`ifdef VRAM_DISPLAY_OUTREG_EN
    logic [DATA_W-1:0] disp2_q, disp2_d;

    assign disp2_d = disp_q;

    // Second display output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp2_q <= '0;
        end else begin
            disp2_q <= disp2_d;
        end
    end

    assign display_rd_data = disp2_q;
`else
    assign display_rd_data = disp_q;
`endif

    assign host.host_rd_data  = rd_data_q;
    assign host.host_rd_valid = rd_valid_q;
    assign host.host_busy     = fill_busy;

endmodule
